uart: RTL and testbench

Full-duplex 8-bit asynchronous serial transceiver with one transmitter and one receiver, both sharing a single clock. Frame format is 1 start bit, 8 data bits LSB first, and 1 stop bit (8N1), with optional even parity. It sits between a parallel byte interface and a serial line, with the baud rate set as an integer number of clock cycles per bit.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 rtl/uart.sv | 149 ++++++++++++++
 tb/tb_uart.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transceiver.
// UART_PARITY_EN adds an even-parity state to both the TX and RX machines.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rxState_t;

    function automatic logic evenParity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// Receive half of the uart: 2-flop synchronizer, mid-bit sampling FSM and byte output.
// UART_PARITY_EN adds a checked even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serialInput,
    output logic [DATA_BITS-1:0] outputData,
    output logic                 rxValid,
    output logic                 rxError
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic                 sync1_r, sync2_r;
    rxState_t             rxState_r, rxNext_s;
    logic [CNT_W-1:0]     rxCnt_r, rxCntNext_s;
    logic [2:0]           rxBit_r, rxBitNext_s;
    logic [DATA_BITS-1:0] rxShift_r, rxShiftNext_s;
    logic [DATA_BITS-1:0] outData_r, outDataNext_s;
    logic                 valid_r, validNext_s;
    logic                 error_r, errorNext_s;
    logic                 parOk_s;
    logic                 cntLast_s;

`ifdef UART_PARITY_EN
    logic rxPar_r, rxParNext_s;
    assign parOk_s = (rxPar_r == evenParity(rxShift_r));
`else
    assign parOk_s = 1'b1;
`endif

    assign cntLast_s  = (rxCnt_r == CNT_LAST);
    assign outputData = outData_r;
    assign rxValid    = valid_r;
    assign rxError    = error_r;

    // Synchronizer and receive state/output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r   <= IDLE_LEVEL;
            sync2_r   <= IDLE_LEVEL;
            rxState_r <= RX_IDLE;
            rxCnt_r   <= CNT_ZERO;
            rxBit_r   <= 3'd0;
            rxShift_r <= 8'h00;
            outData_r <= 8'h00;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
`ifdef UART_PARITY_EN
            rxPar_r   <= 1'b0;
`endif
        end else begin
            sync1_r   <= serialInput;
            sync2_r   <= sync1_r;
            rxState_r <= rxNext_s;
            rxCnt_r   <= rxCntNext_s;
            rxBit_r   <= rxBitNext_s;
            rxShift_r <= rxShiftNext_s;
            outData_r <= outDataNext_s;
            valid_r   <= validNext_s;
            error_r   <= errorNext_s;
`ifdef UART_PARITY_EN
            rxPar_r   <= rxParNext_s;
`endif
        end
    end

    // Receive next-state: start is re-checked at half a bit, later bits one period apart.
    always_comb begin
        rxNext_s      = rxState_r;
        rxCntNext_s   = rxCnt_r;
        rxBitNext_s   = rxBit_r;
        rxShiftNext_s = rxShift_r;
        outDataNext_s = outData_r;
        validNext_s   = 1'b0;
        errorNext_s   = 1'b0;
`ifdef UART_PARITY_EN
        rxParNext_s   = rxPar_r;
`endif
        case (rxState_r)
            RX_IDLE: begin
                rxCntNext_s = CNT_ZERO;
                rxBitNext_s = 3'd0;
                if (sync2_r == 1'b0) begin
                    rxNext_s = RX_START;
                end else begin
                    rxNext_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rxCnt_r == HALF_LAST) begin
                    rxCntNext_s = CNT_ZERO;
                    if (sync2_r == IDLE_LEVEL) begin
                        rxNext_s = RX_IDLE;
                    end else begin
                        rxNext_s = RX_DATA;
                    end
                end else begin
                    rxCntNext_s = rxCnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cntLast_s) begin
                    rxCntNext_s   = CNT_ZERO;
                    rxShiftNext_s = {sync2_r, rxShift_r[DATA_BITS-1:1]};
                    if (rxBit_r == BIT_LAST) begin
                        rxBitNext_s = 3'd0;
`ifdef UART_PARITY_EN
                        rxNext_s    = RX_PARITY;
`else
                        rxNext_s    = RX_STOP;
`endif
                    end else begin
                        rxBitNext_s = rxBit_r + 3'd1;
                    end
                end else begin
                    rxCntNext_s = rxCnt_r + CNT_ONE;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (cntLast_s) begin
                    rxCntNext_s = CNT_ZERO;
                    rxParNext_s = sync2_r;
                    rxNext_s    = RX_STOP;
                end else begin
                    rxCntNext_s = rxCnt_r + CNT_ONE;
                end
            end
`endif
            RX_STOP: begin
                if (cntLast_s) begin
                    rxCntNext_s = CNT_ZERO;
                    rxNext_s    = RX_IDLE;
                    if ((sync2_r == 1'b1) && parOk_s) begin
                        outDataNext_s = rxShift_r;
                        validNext_s   = 1'b1;
                    end else begin
                        errorNext_s   = 1'b1;
                    end
                end else begin
                    rxCntNext_s = rxCnt_r + CNT_ONE;
                end
            end
            default: begin
                rxNext_s    = RX_IDLE;
                rxCntNext_s = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/uart.sv
// Full-duplex 8-bit uart: inline transmitter plus uart_rx receiver.
// UART_PARITY_EN inserts an even-parity bit after the data bits in both directions.
module uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] inputData,
    input  logic                 serialInput,
    output logic                 serialOutput,
    output logic                 txBusy,
    output logic [DATA_BITS-1:0] outputData,
    output logic                 rxValid,
    output logic                 rxError
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    txState_t             txState_r, txNext_s;
    logic [CNT_W-1:0]     txCnt_r, txCntNext_s;
    logic [2:0]           txBit_r, txBitNext_s;
    logic [DATA_BITS-1:0] txData_r, txDataNext_s;
    logic                 txOut_r, txOutNext_s;
    logic                 txBusy_r, txBusyNext_s;
    logic                 cntLast_s;

    assign cntLast_s    = (txCnt_r == CNT_LAST);
    assign serialOutput = txOut_r;
    assign txBusy       = txBusy_r;

    // Transmit state and registered line/busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            txState_r <= TX_IDLE;
            txCnt_r   <= CNT_ZERO;
            txBit_r   <= 3'd0;
            txData_r  <= 8'h00;
            txOut_r   <= IDLE_LEVEL;
            txBusy_r  <= 1'b0;
        end else begin
            txState_r <= txNext_s;
            txCnt_r   <= txCntNext_s;
            txBit_r   <= txBitNext_s;
            txData_r  <= txDataNext_s;
            txOut_r   <= txOutNext_s;
            txBusy_r  <= txBusyNext_s;
        end
    end

    // Transmit next-state: the line value for the next bit is registered on the bit boundary.
    always_comb begin
        txNext_s     = txState_r;
        txCntNext_s  = txCnt_r;
        txBitNext_s  = txBit_r;
        txDataNext_s = txData_r;
        txOutNext_s  = txOut_r;
        txBusyNext_s = txBusy_r;
        case (txState_r)
            TX_IDLE: begin
                txCntNext_s = CNT_ZERO;
                txBitNext_s = 3'd0;
                if (enable) begin
                    txNext_s     = TX_START;
                    txDataNext_s = inputData;
                    txOutNext_s  = 1'b0;
                    txBusyNext_s = 1'b1;
                end else begin
                    txNext_s     = TX_IDLE;
                    txOutNext_s  = IDLE_LEVEL;
                    txBusyNext_s = 1'b0;
                end
            end
            TX_START: begin
                if (cntLast_s) begin
                    txCntNext_s = CNT_ZERO;
                    txNext_s    = TX_DATA;
                    txOutNext_s = txData_r[0];
                end else begin
                    txCntNext_s = txCnt_r + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (cntLast_s) begin
                    txCntNext_s = CNT_ZERO;
                    if (txBit_r == BIT_LAST) begin
                        txBitNext_s = 3'd0;
`ifdef UART_PARITY_EN
                        txNext_s    = TX_PARITY;
                        txOutNext_s = evenParity(txData_r);
`else
                        txNext_s    = TX_STOP;
                        txOutNext_s = IDLE_LEVEL;
`endif
                    end else begin
                        txBitNext_s = txBit_r + 3'd1;
                        txOutNext_s = txData_r[txBit_r + 3'd1];
                    end
                end else begin
                    txCntNext_s = txCnt_r + CNT_ONE;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (cntLast_s) begin
                    txCntNext_s = CNT_ZERO;
                    txNext_s    = TX_STOP;
                    txOutNext_s = IDLE_LEVEL;
                end else begin
                    txCntNext_s = txCnt_r + CNT_ONE;
                end
            end
`endif
            TX_STOP: begin
                if (cntLast_s) begin
                    txCntNext_s  = CNT_ZERO;
                    txNext_s     = TX_IDLE;
                    txOutNext_s  = IDLE_LEVEL;
                    txBusyNext_s = 1'b0;
                end else begin
                    txCntNext_s = txCnt_r + CNT_ONE;
                end
            end
            default: begin
                txNext_s     = TX_IDLE;
                txCntNext_s  = CNT_ZERO;
                txOutNext_s  = IDLE_LEVEL;
                txBusyNext_s = 1'b0;
            end
        endcase
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uRx (
        .clk        (clk),
        .reset      (reset),
        .serialInput(serialInput),
        .outputData (outputData),
        .rxValid    (rxValid),
        .rxError    (rxError)
    );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: frame waveform model, RX vector table, loopback and corner sequences.
module tb_uart;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] inputData;
    logic       serialInput;
    logic       serialOutput;
    logic       txBusy;
    logic [7:0] outputData;
    logic       rxValid;
    logic       rxError;

    logic loopMode = 1'b0;
    logic tbSer = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   validCnt = 0;
    int   errCnt = 0;

    assign serialInput = loopMode ? serialOutput : tbSer;

    uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .inputData   (inputData),
        .serialInput (serialInput),
        .serialOutput(serialOutput),
        .txBusy      (txBusy),
        .outputData  (outputData),
        .rxValid     (rxValid),
        .rxError     (rxError)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxValid) validCnt <= validCnt + 1;
        if (rxError) errCnt <= errCnt + 1;
    end

    // Expected line level for bit slot idx of a frame carrying d.
    function automatic logic frameBit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one whole TX frame starting in its first cycle; optionally scrambles inputData mid-frame.
    task automatic checkFrame(input logic [7:0] d, input bit scramble);
        for (int i = 0; i < NBITS * CPB; i++) begin
            check("txLine", 32'(serialOutput), 32'(frameBit(d, i / CPB)));
            check("txBusy", 32'(txBusy), 32'd1);
            if (scramble && i == 5) inputData = 8'($urandom);
            tick();
        end
    endtask

    task automatic sendTx(input logic [7:0] d, input bit scramble);
        inputData = d;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        checkFrame(d, scramble);
        check("txIdleLine", 32'(serialOutput), 32'd1);
        check("txIdleBusy", 32'(txBusy), 32'd0);
    endtask

    task automatic rxFrame(input logic [7:0] d, input logic stopVal, input logic parFlip);
        logic b;
        loopMode = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            b = frameBit(d, i);
            if (i == NBITS - 1) b = stopVal;
            if (NBITS == 11 && i == 9 && parFlip) b = ~b;
            tbSer = b;
            repeat (CPB) tick();
        end
        tbSer = 1'b1;
        repeat (8) tick();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopVal;
        logic       parFlip;
        int         expValid;
        int         expError;
        logic [7:0] expData;
    } rxVec_t;

    rxVec_t vecs[6];

    initial begin
        int v0, e0;
        logic [7:0] d;
        logic [7:0] held;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 0, 1, 8'h00};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 1, 0, 8'h81};
`ifdef UART_PARITY_EN
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 0, 1, 8'h81};
`else
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 1, 0, 8'h7E};
`endif

        reset = 1'b1;
        enable = 1'b0;
        inputData = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        check("rstLine", 32'(serialOutput), 32'd1);
        check("rstBusy", 32'(txBusy), 32'd0);
        check("rstData", 32'(outputData), 32'd0);
        check("rstValid", 32'(rxValid), 32'd0);
        check("rstError", 32'(rxError), 32'd0);

        // Transmit 8'hAA in loopback; the receiver must see exactly one good byte.
        loopMode = 1'b1;
        v0 = validCnt; e0 = errCnt;
        sendTx(8'hAA, 1'b1);
        repeat (6) tick();
        check("loopValidCnt", 32'(validCnt - v0), 32'd1);
        check("loopErrCnt", 32'(errCnt - e0), 32'd0);
        check("loopData", 32'(outputData), 32'hAA);

        // Back-to-back frames with enable held: one idle-high cycle in between.
        loopMode = 1'b0;
        inputData = 8'h55;
        enable = 1'b1;
        tick();
        checkFrame(8'h55, 1'b0);
        check("gapLine", 32'(serialOutput), 32'd1);
        check("gapBusy", 32'(txBusy), 32'd0);
        tick();
        enable = 1'b0;
        checkFrame(8'h55, 1'b0);
        check("b2bEndLine", 32'(serialOutput), 32'd1);
        check("b2bEndBusy", 32'(txBusy), 32'd0);
        tick();
        check("b2bNoThird", 32'(txBusy), 32'd0);

        // RX vector table.
        for (int k = 0; k < 6; k++) begin
            v0 = validCnt; e0 = errCnt;
            rxFrame(vecs[k].data, vecs[k].stopVal, vecs[k].parFlip);
            check($sformatf("vec%0d_valid", k), 32'(validCnt - v0), 32'(vecs[k].expValid));
            check($sformatf("vec%0d_error", k), 32'(errCnt - e0), 32'(vecs[k].expError));
            check($sformatf("vec%0d_data", k), 32'(outputData), 32'(vecs[k].expData));
        end

        // Single-cycle low glitch must be rejected silently.
        held = outputData;
        v0 = validCnt; e0 = errCnt;
        tbSer = 1'b0;
        tick();
        tbSer = 1'b1;
        repeat (20) tick();
        check("glitchValid", 32'(validCnt - v0), 32'd0);
        check("glitchError", 32'(errCnt - e0), 32'd0);
        check("glitchData", 32'(outputData), 32'(held));

        // Random bytes through the loopback, checked against the frame model.
        loopMode = 1'b1;
        for (int r = 0; r < 10; r++) begin
            d = 8'($urandom);
            v0 = validCnt; e0 = errCnt;
            sendTx(d, 1'b1);
            repeat (6) tick();
            check("rndValidCnt", 32'(validCnt - v0), 32'd1);
            check("rndErrCnt", 32'(errCnt - e0), 32'd0);
            check("rndData", 32'(outputData), 32'(d));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset during the 4th data bit, then a clean frame.
        loopMode = 1'b0;
        tbSer = 1'b1;
        inputData = 8'hAA;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (17) tick();
        check("midLine", 32'(serialOutput), 32'(frameBit(8'hAA, 4)));
        reset = 1'b1;
        tick();
        check("abortLine", 32'(serialOutput), 32'd1);
        check("abortBusy", 32'(txBusy), 32'd0);
        check("abortData", 32'(outputData), 32'd0);
        reset = 1'b0;
        tick();
        sendTx(8'hAA, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
